gate_op_scheduler: RTL and testbench

//  Shares one registered 2-bit logic-gate unit among NUM_REQ requesters.

---
 rtl/gate_pkg.sv | 23 ++
 rtl/logic_gate_unit.sv | 50 +++++
 rtl/gate_op_scheduler.sv | 144 ++++++++++++++
 tb/tb_gate_op_scheduler.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_pkg.sv
// rtl/gate_pkg.sv - opcode and FSM state encodings for the gate op scheduler
//
// Contents:
//   OP_AND..OP_PASSA : 3-bit opcodes understood by logic_gate_unit
//   state_t          : scheduler FSM states ST_IDLE / ST_EXEC / ST_RESP
package gate_pkg;

    localparam logic [2:0] OP_AND   = 3'd0;
    localparam logic [2:0] OP_OR    = 3'd1;
    localparam logic [2:0] OP_XOR   = 3'd2;
    localparam logic [2:0] OP_NAND  = 3'd3;
    localparam logic [2:0] OP_NOR   = 3'd4;
    localparam logic [2:0] OP_XNOR  = 3'd5;
    localparam logic [2:0] OP_NOTA  = 3'd6;
    localparam logic [2:0] OP_PASSA = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/logic_gate_unit.sv
// rtl/logic_gate_unit.sv - registered bitwise logic-gate datapath
//
// Ports:
//   clk  in  rising-edge clock
//   rst  in  asynchronous active-low reset (clears y)
//   a    in  operand A
//   b    in  operand B
//   op   in  opcode (gate_pkg encodings)
//   y    out registered result, updated every clock
module logic_gate_unit
    import gate_pkg::*;
#(
    parameter int DATA_W = 2,
    parameter int OP_W   = 3
)(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OP_W-1:0]   op,
    output logic [DATA_W-1:0] y
);

    logic [DATA_W-1:0] w_y;

    always_comb begin
        w_y = '0;
        case (3'(op))
            OP_AND:   w_y = a & b;
            OP_OR:    w_y = a | b;
            OP_XOR:   w_y = a ^ b;
            OP_NAND:  w_y = ~(a & b);
            OP_NOR:   w_y = ~(a | b);
            OP_XNOR:  w_y = ~(a ^ b);
            OP_NOTA:  w_y = ~a;
            OP_PASSA: w_y = a;
        endcase
    end

    // Operands are held constant by the scheduler through EXEC and RESP,
    // so registering every cycle keeps y stable while a response waits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            y <= '0;
        end else begin
            y <= w_y;
        end
    end

endmodule

// File: rtl/gate_op_scheduler.sv
// rtl/gate_op_scheduler.sv - round-robin scheduler sharing one logic-gate unit
//
// Ports:
//   clk, rst    clock and asynchronous active-low reset
//   req_valid   per-requester request valid
//   req_ready   per-requester accept, one-hot or zero, only in IDLE
//   req_a/b     packed operands, requester i at [i*DATA_W +: DATA_W]
//   req_op      packed opcodes, requester i at [i*OP_W +: OP_W]
//   rsp_valid   result valid, held until rsp_ready
//   rsp_ready   consumer accepts result
//   rsp_data    result
//   rsp_id      index of the requester that owns rsp_data
//   busy        high whenever the FSM is not in IDLE
module gate_op_scheduler
    import gate_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 2,
    parameter int OP_W    = 3,
    parameter int ID_W    = $clog2(NUM_REQ)
)(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ*OP_W-1:0]   req_op,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [ID_W-1:0]           rsp_id,
    output logic                      busy
);

    state_t            r_state;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [ID_W-1:0]   r_id;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [OP_W-1:0]   r_op;
    logic              r_rsp_valid;

    logic              w_found;
    logic [ID_W-1:0]   w_grant;
    logic [DATA_W-1:0] w_sel_a;
    logic [DATA_W-1:0] w_sel_b;
    logic [OP_W-1:0]   w_sel_op;
    logic [DATA_W-1:0] w_y;

    // Search starts just after the last served requester, so the one served
    // most recently has the lowest priority next time.
    always_comb begin : rr_search
        int idx;
        w_found = 1'b0;
        w_grant = '0;
        idx     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(r_rr_ptr) + k) % NUM_REQ;
            if (!w_found && req_valid[idx]) begin
                w_found = 1'b1;
                w_grant = ID_W'(idx);
            end
        end
    end

    always_comb begin
        w_sel_a  = '0;
        w_sel_b  = '0;
        w_sel_op = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant == ID_W'(i)) begin
                w_sel_a  = req_a[i*DATA_W +: DATA_W];
                w_sel_b  = req_b[i*DATA_W +: DATA_W];
                w_sel_op = req_op[i*OP_W +: OP_W];
            end
        end
    end

    // Gated with rst so no requester sees an accept while reset is held.
    always_comb begin
        req_ready = '0;
        if (rst && r_state == ST_IDLE && w_found) begin
            req_ready[w_grant] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= ID_W'(NUM_REQ - 1);
            r_id        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= '0;
            r_rsp_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_a     <= w_sel_a;
                        r_b     <= w_sel_b;
                        r_op    <= w_sel_op;
                        r_id    <= w_grant;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_rsp_valid <= 1'b1;
                    r_state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rr_ptr    <= r_id;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    logic_gate_unit #(
        .DATA_W (DATA_W),
        .OP_W   (OP_W)
    ) u_gate (
        .clk (clk),
        .rst (rst),
        .a   (r_a),
        .b   (r_b),
        .op  (r_op),
        .y   (w_y)
    );

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = w_y;
    assign rsp_id    = r_id;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_gate_op_scheduler.sv
// tb/tb_gate_op_scheduler.sv - self-checking bench for gate_op_scheduler
module tb_gate_op_scheduler;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req_valid;
    logic [N-1:0] req_ready;
    logic [2*N-1:0] req_a;
    logic [2*N-1:0] req_b;
    logic [3*N-1:0] req_op;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [1:0]   rsp_data;
    logic [1:0]   rsp_id;
    logic         busy;

    gate_op_scheduler #(
        .NUM_REQ (N),
        .DATA_W  (2),
        .OP_W    (3),
        .ID_W    (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Requester-side stimulus state
    logic [N-1:0] v;
    logic [1:0]   a_r  [N];
    logic [1:0]   b_r  [N];
    logic [2:0]   op_r [N];
    bit           auto_release;

    // Transaction-level reference model
    bit         m_out;
    int         m_age;
    int         m_id;
    logic [1:0] m_data;
    int         m_last;
    int         m_acc;
    int         got_id[$];
    logic [1:0] got_data[$];

    int n_checks = 0;
    int n_pass   = 0;

    logic [1:0] t3_exp [8] = '{2'b01, 2'b11, 2'b10, 2'b10, 2'b00, 2'b01, 2'b10, 2'b01};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [1:0] gate_ref(input logic [1:0] a, input logic [1:0] b, input int op);
        case (op)
            0: return a & b;
            1: return a | b;
            2: return a ^ b;
            3: return ~(a & b);
            4: return ~(a | b);
            5: return ~(a ^ b);
            6: return ~a;
            default: return a;
        endcase
    endfunction

    function automatic int rr_pick(input logic [N-1:0] vv);
        for (int k = 1; k <= N; k++) begin
            if (vv[(m_last + k) % N]) return (m_last + k) % N;
        end
        return -1;
    endfunction

    task automatic drive_inputs();
        req_valid = v;
        for (int i = 0; i < N; i++) begin
            req_a[i*2 +: 2]  = a_r[i];
            req_b[i*2 +: 2]  = b_r[i];
            req_op[i*3 +: 3] = op_r[i];
        end
    endtask

    task automatic model_check();
        logic [N-1:0] exp_rdy;
        int g;
        exp_rdy = '0;
        m_acc   = -1;
        if (!m_out) begin
            g = rr_pick(v);
            if (g >= 0) exp_rdy[g] = 1'b1;
            check("req_ready_idle", req_ready, exp_rdy);
            check("busy_idle", busy, 0);
            check("rsp_valid_idle", rsp_valid, 0);
            if (g >= 0) begin
                m_out  = 1'b1;
                m_age  = 0;
                m_id   = g;
                m_data = gate_ref(a_r[g], b_r[g], int'(op_r[g]));
                m_acc  = g;
            end
        end else begin
            m_age++;
            check("req_ready_busy", req_ready, 0);
            check("busy_busy", busy, 1);
            if (m_age == 1) begin
                check("rsp_valid_exec", rsp_valid, 0);
            end else begin
                check("rsp_valid_resp", rsp_valid, 1);
                check("rsp_data", rsp_data, m_data);
                check("rsp_id", rsp_id, m_id);
                if (rsp_ready) begin
                    m_out  = 1'b0;
                    m_last = m_id;
                    got_id.push_back(int'(rsp_id));
                    got_data.push_back(rsp_data);
                end
            end
        end
    endtask

    // One clock: drive at the falling edge, check 1ns later, wait next fall.
    task automatic step();
        drive_inputs();
        #1;
        model_check();
        if (auto_release && m_acc >= 0) v[m_acc] = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_until(input int n);
        int k = 0;
        while (got_id.size() < n && k < 80) begin
            step();
            k++;
        end
        check("resp_count", got_id.size(), n);
    endtask

    task automatic set_req(input int i, input logic [1:0] a, input logic [1:0] b, input logic [2:0] op);
        a_r[i]  = a;
        b_r[i]  = b;
        op_r[i] = op;
        v[i]    = 1'b1;
    endtask

    initial begin
        int base;
        int k;
        v = '0;
        for (int i = 0; i < N; i++) begin
            a_r[i] = '0; b_r[i] = '0; op_r[i] = '0;
        end
        m_out = 1'b0; m_age = 0; m_id = 0; m_data = '0; m_last = N - 1; m_acc = -1;
        auto_release = 1'b1;
        rsp_ready = 1'b1;
        rst = 1'b0;
        v = 4'b1111;
        drive_inputs();
        #1;
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_busy", busy, 0);
        check("rst_req_ready", req_ready, 0);
        @(negedge clk);
        rst = 1'b1;
        v = '0;

        // T1: reset while a response is stalled
        set_req(0, 2'b10, 2'b01, 3'd1);
        rsp_ready = 1'b0;
        step(); step(); step();
        check("t1_in_resp", rsp_valid, 1);
        v = 4'b1111;
        drive_inputs();
        #2 rst = 1'b0;
        #1;
        check("t1_rsp_valid", rsp_valid, 0);
        check("t1_busy", busy, 0);
        check("t1_req_ready", req_ready, 0);
        m_out = 1'b0; m_last = N - 1;
        @(negedge clk);
        rst = 1'b1;
        rsp_ready = 1'b1;

        // T4: all requesters held valid -> strict rotation starting at 0
        auto_release = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 2'(i), 2'(3 - i), 3'(i));
        got_id.delete(); got_data.delete();
        run_until(8);
        for (int i = 0; i < 8; i++) check("t4_rotation", got_id[i], i % 4);
        v = '0;
        auto_release = 1'b1;

        // T2: single op from requester 1
        got_id.delete(); got_data.delete();
        set_req(1, 2'b11, 2'b10, 3'd0);
        run_until(1);
        check("t2_data", got_data[0], 2'b10);
        check("t2_id", got_id[0], 1);

        // T3: every opcode on a=01 b=11
        got_id.delete(); got_data.delete();
        for (int o = 0; o < 8; o++) begin
            set_req(0, 2'b01, 2'b11, 3'(o));
            run_until(o + 1);
            check("t3_opcode", got_data[o], t3_exp[o]);
        end

        // T5: response backpressure for 10 clocks with other requests waiting
        got_id.delete(); got_data.delete();
        set_req(2, 2'b10, 2'b11, 3'd2);
        rsp_ready = 1'b0;
        step(); step();
        v = 4'b1011;
        for (int i = 0; i < 10; i++) step();
        check("t5_stalled", got_id.size(), 0);
        v = '0;
        rsp_ready = 1'b1;
        run_until(1);
        check("t5_id", got_id[0], 2);
        check("t5_data", got_data[0], 2'b01);

        // T6: last grant 1, valid=1010 -> 3 then 1
        got_id.delete(); got_data.delete();
        set_req(1, 2'b00, 2'b00, 3'd4);
        run_until(1);
        auto_release = 1'b0;
        set_req(1, 2'b01, 2'b10, 3'd1);
        set_req(3, 2'b11, 2'b01, 3'd3);
        run_until(3);
        check("t6_first", got_id[1], 3);
        check("t6_second", got_id[2], 1);
        v = '0;
        auto_release = 1'b1;

        // Randomized traffic with random backpressure and early drops
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!v[i] && $urandom_range(0, 2) == 0) begin
                    set_req(i, 2'($urandom), 2'($urandom), 3'($urandom));
                end else if (v[i] && m_out && $urandom_range(0, 15) == 0) begin
                    v[i] = 1'b0;
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        v = '0;
        rsp_ready = 1'b1;
        k = 0;
        while (m_out && k < 20) begin
            step();
            k++;
        end
        check("drain", m_out, 0);
        base = got_id.size();
        step();
        check("quiet_after_drain", got_id.size(), base);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
